// File: rtl/axis_downsizer_ext.sv
// AXI4-Stream width reducer: splits each wide input beat into up to RATIO narrow words,
// with run-time slice count/order and a 2-entry registered skid buffer on the output.
module axis_downsizer_ext #(
  parameter int S_AXIS_TDATA_WIDTH = 128,
  parameter int M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [15:0]                   cfg_data,
  input  logic                          cfg_order,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [31:0]                   sts_data
);

  localparam int RATIO      = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH;
  localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNTR_WIDTH-1:0] LAST_MAX = CNTR_WIDTH'(RATIO - 1);

  // Out-of-range requests clamp to the widest split instead of wrapping.
  function automatic logic [CNTR_WIDTH-1:0] clamp_last(input logic [15:0] v);
    if (RATIO == 1) return '0;
    if (int'({16'd0, v}) > RATIO - 1) return LAST_MAX;
    return v[CNTR_WIDTH-1:0];
  endfunction

  logic [M_AXIS_TDATA_WIDTH-1:0] slices [RATIO];
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = s_axis_tdata[g*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
  end

  logic [CNTR_WIDTH-1:0] cnt, sh_last, eff_last, slice_idx;
  logic                  sh_order, eff_order, last_slice;
  logic                  buf_free, accept, pop;
  logic [M_AXIS_TDATA_WIDTH-1:0] push_data, skid_data;
  logic                  push_last, skid_last, skid_vld, skid_vld_n;

  // Slice 0 sees live cfg; later slices of the same beat use the shadow copy.
  assign eff_last   = (cnt == '0) ? clamp_last(cfg_data) : sh_last;
  assign eff_order  = (cnt == '0) ? cfg_order : sh_order;
  assign last_slice = (cnt == eff_last);
  assign slice_idx  = eff_order ? (eff_last - cnt) : cnt;
  assign push_data  = slices[slice_idx];
  assign push_last  = s_axis_tlast & last_slice;

  assign accept        = s_axis_tvalid & buf_free;
  assign s_axis_tready = (RATIO == 1) ? buf_free : (accept & last_slice);
  assign pop           = m_axis_tvalid & m_axis_tready;

  always_comb begin
    skid_vld_n = skid_vld;
    if (pop)                          skid_vld_n = 1'b0;
    else if (accept && m_axis_tvalid) skid_vld_n = 1'b1;
  end

  // Slice counter, shadow cfg and beat counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt      <= '0;
      sh_last  <= '0;
      sh_order <= 1'b0;
      sts_data <= '0;
    end else begin
      if (accept) begin
        if (cnt == '0) begin
          sh_last  <= clamp_last(cfg_data);
          sh_order <= cfg_order;
        end
        cnt <= last_slice ? '0 : cnt + 1'b1;
      end
      if (s_axis_tvalid && s_axis_tready) sts_data <= sts_data + 32'd1;
    end
  end

  // Output stage: head register drives the port, skid entry absorbs one word of backpressure
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      skid_vld      <= 1'b0;
      buf_free      <= 1'b0;
    end else begin
      skid_vld <= skid_vld_n;
      buf_free <= ~skid_vld_n;
      if (pop && skid_vld) begin
        m_axis_tdata <= skid_data;
        m_axis_tlast <= skid_last;
      end else if (pop) begin
        if (accept) begin
          m_axis_tdata <= push_data;
          m_axis_tlast <= push_last;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (accept && !m_axis_tvalid) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= push_data;
        m_axis_tlast  <= push_last;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (accept && m_axis_tvalid && !pop) begin
      skid_data <= push_data;
      skid_last <= push_last;
    end
  end

endmodule

// File: tb/tb_axis_downsizer_ext.sv
// Bench for axis_downsizer_ext (128 -> 32): directed beats, queue-based word model, per-cycle output compare.
module tb_axis_downsizer_ext;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [15:0]  cfg_data = 16'd3;
  logic         cfg_order = 1'b0;
  logic [127:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic [31:0]  sts_data;

  axis_downsizer_ext #(.S_AXIS_TDATA_WIDTH(128), .M_AXIS_TDATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .cfg_order(cfg_order),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .sts_data(sts_data)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int beats = 0;
  bit rand_rdy = 0;
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] got_d[$];
  logic        got_l[$];

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] D3 = 128'hdddd0004_cccc0003_bbbb0002_aaaa0001;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Expected words of one beat, straight from the slicing rule.
  function automatic void model_beat(input logic [127:0] d, input logic l,
                                     input logic [15:0] cfg, input logic ord);
    int last;
    int j;
    last = (cfg > 16'd3) ? 3 : int'(cfg);
    for (int k = 0; k <= last; k++) begin
      j = ord ? (last - k) : k;
      exp_d.push_back(d[j*32 +: 32]);
      exp_l.push_back(l && (k == last));
    end
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic l, output int cyc);
    bit hs;
    model_beat(d, l, cfg_data, cfg_order);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    cyc = 0;
    hs = 0;
    while (!hs && cyc < 2000) begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      cyc++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL beat_timeout actual=%0d required=handshake", cyc);
    end
    #1;
    s_axis_tvalid = 1'b0;
    beats++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_d.size() != 0 && n < 20000) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk("drain_left", exp_d.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every output handshake against the model, plus hold-while-stalled.
  initial begin
    bit          prev_stall = 0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", m_axis_tvalid, 1'b1);
        chk("hold_data", m_axis_tdata, prev_d);
        chk("hold_last", m_axis_tlast, prev_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word actual=%0h required=none", m_axis_tdata);
        end else begin
          chk("word_data", m_axis_tdata, exp_d.pop_front());
          chk("word_last", m_axis_tlast, exp_l.pop_front());
        end
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    int nl;
    logic [127:0] rd;

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_mvalid", m_axis_tvalid, 1'b0);
    chk("rst_mdata", m_axis_tdata, 32'd0);
    chk("rst_mlast", m_axis_tlast, 1'b0);
    chk("rst_sready", s_axis_tready, 1'b0);
    chk("rst_sts", sts_data, 32'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // 1: four words LSB first, tready every 4th cycle
    base = got_d.size();
    cfg_data = 16'd3; cfg_order = 1'b0;
    send_beat(D1, 1'b0, c);
    chk("t1_cyc_a", c, 4);
    send_beat(D2, 1'b0, c);
    chk("t1_cyc_b", c, 4);
    chk("t1_sts", sts_data, 32'd2);
    drain();
    chk("t1_w0", got_d[base], 32'h11111111);
    chk("t1_w3", got_d[base+3], 32'h44444444);
    chk("t1_w4", got_d[base+4], 32'h55555555);

    // 2: two slices descending, then a clamped cfg
    base = got_d.size();
    cfg_data = 16'd1; cfg_order = 1'b1;
    send_beat(D1, 1'b0, c);
    chk("t2_cyc", c, 2);
    drain();
    chk("t2_w0", got_d[base], 32'h22222222);
    chk("t2_w1", got_d[base+1], 32'h11111111);
    base = got_d.size();
    cfg_data = 16'd9; cfg_order = 1'b0;
    send_beat(D1, 1'b0, c);
    chk("t2_clamp_cyc", c, 4);
    drain();
    chk("t2_clamp_n", got_d.size() - base, 4);
    chk("t2_clamp_w3", got_d[base+3], 32'h44444444);

    // 3: tlast on beat 2 of 3 lands on word 8 only
    base = got_d.size();
    cfg_data = 16'd3; cfg_order = 1'b0;
    send_beat(D1, 1'b0, c);
    send_beat(D2, 1'b1, c);
    send_beat(D3, 1'b0, c);
    drain();
    nl = 0;
    for (int i = base; i < got_l.size(); i++) nl += int'(got_l[i]);
    chk("t3_last_cnt", nl, 1);
    chk("t3_last_w8", got_l[base+7], 1'b1);
    chk("t3_w8", got_d[base+7], 32'h88888888);

    // 4: random backpressure, random cfg per beat
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      cfg_data  = 16'($urandom_range(0, 5));
      cfg_order = 1'($urandom_range(0, 1));
      rd = {$urandom, $urandom, $urandom, $urandom};
      send_beat(rd, 1'($urandom_range(0, 1)), c);
    end
    drain();
    rand_rdy = 0;
    repeat (2) @(posedge aclk);
    #1;
    chk("t4_sts", sts_data, beats);

    // 5: cfg change mid-beat only affects following beats
    base = got_d.size();
    cfg_data = 16'd3; cfg_order = 1'b0;
    model_beat(D1, 1'b0, 16'd3, 1'b0);
    s_axis_tdata = D1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    c = 0;
    begin
      bit hs = 0;
      while (!hs && c < 200) begin
        @(negedge aclk);
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge aclk);
        c++;
        if (c == 2) #1 cfg_data = 16'd0;
      end
    end
    #1;
    s_axis_tvalid = 1'b0;
    beats++;
    chk("t5_cyc_cur", c, 4);
    send_beat(D2, 1'b0, c);
    chk("t5_cyc_n1", c, 1);
    send_beat(D3, 1'b0, c);
    chk("t5_cyc_n2", c, 1);
    drain();
    chk("t5_n", got_d.size() - base, 6);
    chk("t5_w4", got_d[base+4], 32'h55555555);
    chk("t5_w5", got_d[base+5], 32'haaaa0001);

    // 6: reset mid-beat, beat re-presented from slice 0
    cfg_data = 16'd3; cfg_order = 1'b0;
    model_beat(D3, 1'b0, 16'd3, 1'b0);
    s_axis_tdata = D3; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b0;
    exp_d.delete();
    exp_l.delete();
    beats = 0;
    @(posedge aclk);
    @(negedge aclk);
    chk("t6_mvalid", m_axis_tvalid, 1'b0);
    chk("t6_mdata", m_axis_tdata, 32'd0);
    chk("t6_mlast", m_axis_tlast, 1'b0);
    chk("t6_sready", s_axis_tready, 1'b0);
    chk("t6_sts", sts_data, 32'd0);
    aresetn = 1'b1;
    base = got_d.size();
    send_beat(D3, 1'b0, c);
    drain();
    chk("t6_w0", got_d[base], 32'haaaa0001);
    chk("t6_w3", got_d[base+3], 32'hdddd0004);
    chk("t6_sts_after", sts_data, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
